// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes, counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Wide enough for 9 data bits or 2 stop bits.
  localparam int IDX_W = 4;

  function automatic int cnt_width(input int os);
    return (os <= 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: synchroniser, armed falling-edge detect and 2-of-3 bit voter.
module uart_rx_sampler #(
  parameter int OVERSAMPLING = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_rx,
  input  logic             i_baud,
  input  logic             i_disarm,
  input  logic [CNT_W-1:0] i_tick,
  output logic             o_rx,
  output logic             o_start,
  output logic             o_bit,
  output logic             o_bit_stb
);

  localparam logic [CNT_W-1:0] T_LO  = CNT_W'(OVERSAMPLING/2 - 1);
  localparam logic [CNT_W-1:0] T_MID = CNT_W'(OVERSAMPLING/2);
  localparam logic [CNT_W-1:0] T_HI  = CNT_W'(OVERSAMPLING/2 + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q, armed_q, s0_q, s1_q;

  // fill_q marks when sync_q holds real line samples rather than reset ones,
  // so a line held low through reset never arms the edge detector.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_q  <= '1;
      fill_q  <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= o_rx;
      if (i_disarm)                          armed_q <= 1'b0;
      else if (fill_q[SYNC_STAGES-1] && o_rx) armed_q <= 1'b1;
      if (i_baud && i_tick == T_LO)  s0_q <= o_rx;
      if (i_baud && i_tick == T_MID) s1_q <= o_rx;
    end
  end

  assign o_rx      = sync_q[SYNC_STAGES-1];
  assign o_start   = armed_q & prev_q & ~o_rx;
  assign o_bit     = (s0_q & s1_q) | (s0_q & o_rx) | (s1_q & o_rx);
  assign o_bit_stb = i_baud && (i_tick == T_HI);

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver with parity/frame/break/overrun flags on a valid/ready register.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int NDATA_BITS   = 8,
  parameter int NSTOP_BITS   = 1,
  parameter int OVERSAMPLING = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx,
  input  logic                  i_baud,
  output logic [NDATA_BITS-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun
);

  localparam int               CNT_W     = cnt_width(OVERSAMPLING);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLING - 1);
  localparam logic             ODD_BIT   = PARITY_ODD ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      tick_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NDATA_BITS-1:0] shift_q;
  logic                  par_q, ferr_q, stop0_low_q;
  logic                  rx_s, start, bit_v, bit_stb, bit_end, done;
  logic                  stop0_low, frame_brk, frame_ferr, frame_perr;

  uart_rx_sampler #(
    .OVERSAMPLING(OVERSAMPLING),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) u_sampler (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_rx     (i_rx),
    .i_baud   (i_baud),
    .i_disarm (state_q == ST_WAIT_IDLE),
    .i_tick   (tick_q),
    .o_rx     (rx_s),
    .o_start  (start),
    .o_bit    (bit_v),
    .o_bit_stb(bit_stb)
  );

  assign bit_end = i_baud && (tick_q == TICK_LAST);

  // Frame verdict, valid while sampling the last stop bit.
  assign stop0_low  = (idx_q == '0) ? ~bit_v : stop0_low_q;
  assign frame_brk  = (shift_q == '0) && (!PARITY_EN || !par_q) && stop0_low;
  assign frame_ferr = ferr_q | ~bit_v;
  assign frame_perr = PARITY_EN && !frame_brk && ((^shift_q) ^ par_q ^ ODD_BIT);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_START;
      ST_START: begin
        if (bit_stb && bit_v) state_d = ST_IDLE;
        else if (bit_end)     state_d = ST_DATA;
      end
      ST_DATA:
        if (bit_end && idx_q == IDX_W'(NDATA_BITS - 1))
          state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        // Completes mid-bit so the next start edge is never missed.
        if (bit_stb && idx_q == IDX_W'(NSTOP_BITS - 1)) begin
          done    = 1'b1;
          state_d = frame_brk ? ST_WAIT_IDLE : ST_IDLE;
        end
      end
      ST_WAIT_IDLE: if (i_baud && rx_s && tick_q == TICK_LAST) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tick_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ferr_q      <= 1'b0;
      stop0_low_q <= 1'b0;
    end else begin
      // WAIT_IDLE reuses the tick counter to time one full high bit.
      if ((state_q == ST_IDLE && start) || done)
        tick_q <= '0;
      else if (state_q == ST_WAIT_IDLE && i_baud && !rx_s)
        tick_q <= '0;
      else if (i_baud)
        tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + CNT_W'(1);

      if (state_q != state_d)
        idx_q <= '0;
      else if (bit_end && (state_q == ST_DATA || state_q == ST_STOP))
        idx_q <= idx_q + IDX_W'(1);

      if (state_q == ST_DATA && bit_stb)   shift_q <= {bit_v, shift_q[NDATA_BITS-1:1]};
      if (state_q == ST_PARITY && bit_stb) par_q   <= bit_v;

      if (state_q == ST_IDLE)
        ferr_q <= 1'b0;
      else if (state_q == ST_STOP && bit_stb && !bit_v)
        ferr_q <= 1'b1;
      if (state_q == ST_STOP && bit_stb && idx_q == '0)
        stop0_low_q <= ~bit_v;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (done && (!o_valid || i_ready)) begin
      o_data       <= shift_q;
      o_valid      <= 1'b1;
      o_parity_err <= frame_perr;
      o_frame_err  <= frame_ferr;
      o_break      <= frame_brk;
      o_overrun    <= 1'b0;
    end else if (o_valid && i_ready) begin
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (done) begin
      o_overrun <= 1'b1;
    end
  end

endmodule
